// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and counter widths for the pipeline control FSM.
package pipe_ctrl_pkg;

    localparam int unsigned CntW = 4;
    localparam int unsigned WdW  = 8;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMulti   = 2'd1,
        StMemWait = 2'd2
    } state_t;

endpackage

// File: rtl/mem_watchdog.sv
// Memory-wait watchdog: saturating wait counter and sticky timeout flag.
module mem_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic enter_i,
    input  logic in_wait_i,
    input  logic mem_busy_i,
    output logic mem_err_o
);

    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q, err_d;
    logic           at_limit;

    assign at_limit = (wd_q == WdW'(MEM_TIMEOUT));

    always_comb begin
        wd_d  = wd_q;
        err_d = err_q;
        if (in_wait_i) begin
            if (mem_busy_i) begin
                if (at_limit) begin
                    err_d = 1'b1;
                end else begin
                    wd_d = wd_q + WdW'(1);
                end
            end else begin
                wd_d = '0;
            end
        end else if (enter_i) begin
            // The entering RUN cycle already counts as the first busy cycle.
            wd_d = WdW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign mem_err_o = !rst && (err_q || (in_wait_i && mem_busy_i && at_limit));

endmodule

// File: rtl/pipeline_control_fsm.sv
// Pipeline stall/flush controller. Define STALL_COUNTER_EN to enable the
// stall_cycles performance counter; otherwise it reads as zero.
module pipeline_control_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT     = 4,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_stall,
    input  logic        br_taken,
    input  logic        mul_start,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        mem_wb_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_err,
    output logic [15:0] stall_cycles
);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if (rst) begin
            {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
            {if_id_flush, id_ex_flush, ex_mem_flush} = '1;
        end else begin
            unique case (state_q)
                // A MEM_WAIT cycle with memory ready is decoded like RUN.
                StRun, StMemWait: begin
                    if (mem_busy) begin
                        {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
                        state_d = StMemWait;
                    end else if (br_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_d     = StRun;
                    end else if (hazard_stall) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        state_d     = StRun;
                    end else if (mul_start) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        cnt_d        = CntW'(MUL_LAT - 2);
                        state_d      = StMulti;
                    end else begin
                        state_d = StRun;
                    end
                end
                StMulti: begin
                    if (cnt_q != '0) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        cnt_d        = cnt_q - CntW'(1);
                    end
                    if (mem_busy) begin
                        ex_mem_write = 1'b0;
                        mem_wb_write = 1'b0;
                    end else if (cnt_q == '0) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    mem_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_watchdog (
        .clk       (clk),
        .rst       (rst),
        .enter_i   (state_q == StRun && mem_busy),
        .in_wait_i (state_q == StMemWait),
        .mem_busy_i(mem_busy),
        .mem_err_o (mem_err)
    );

`ifdef STALL_COUNTER_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!pc_write && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
